// File: rtl/hvac_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hvac_pkg
// Brief    : State encoding, mode constants and default timings for hvac_sequencer
// Revision : 1.0
// ============================================================================
package hvac_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_HEAT = 3'd2;
  localparam logic [2:0] ST_COOL = 3'd3;
  localparam logic [2:0] ST_POST = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_PRE  = ST_PRE,
    S_HEAT = ST_HEAT,
    S_COOL = ST_COOL,
    S_POST = ST_POST
  } state_e;

  localparam logic MODE_HEAT = 1'b0;
  localparam logic MODE_COOL = 1'b1;

  localparam int DEF_PRE_CYCLES  = 4;
  localparam int DEF_MIN_ON      = 8;
  localparam int DEF_POST_CYCLES = 4;
  localparam int DEF_MIN_OFF     = 16;
  localparam int DEF_CW          = 8;

endpackage
`default_nettype wire

// File: rtl/hvac_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : hvac_sequencer_if
// Brief    : Request/actuator bundle between the ac controller and the sequencer
// Revision : 1.0
// ============================================================================
interface hvac_sequencer_if;
  import hvac_pkg::*;

  logic       heat_req;
  logic       cool_req;
  logic       fan_on;
  logic       heater_on;
  logic       compressor_on;
  logic       lockout;
  logic       conflict;
  logic [2:0] state;

  modport master (
    output heat_req, cool_req,
    input  fan_on, heater_on, compressor_on, lockout, conflict, state
  );

  modport slave (
    input  heat_req, cool_req,
    output fan_on, heater_on, compressor_on, lockout, conflict, state
  );

endinterface
`default_nettype wire

// File: rtl/hvac_downcounter.sv
`default_nettype none
// ============================================================================
// Module   : hvac_downcounter
// Brief    : Loadable down-counter that saturates at zero and flags zero
// Revision : 1.0
// ============================================================================
module hvac_downcounter
  import hvac_pkg::*;
#(
  parameter int CW = DEF_CW
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic          i_load,
  input  wire logic [CW-1:0] i_load_val,
  input  wire logic          i_en,
  output logic               o_zero
);

  logic [CW-1:0] r_count;

  // Load has priority so a reload on the same edge as a decrement wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/hvac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : hvac_sequencer
// Brief    : Fan/heater/compressor sequencing with purge, min-run and lockout
// Revision : 1.0
// ============================================================================
module hvac_sequencer
  import hvac_pkg::*;
#(
  parameter int PRE_CYCLES  = DEF_PRE_CYCLES,
  parameter int MIN_ON      = DEF_MIN_ON,
  parameter int POST_CYCLES = DEF_POST_CYCLES,
  parameter int MIN_OFF     = DEF_MIN_OFF,
  parameter int CW          = DEF_CW
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  hvac_sequencer_if.slave bus
);

  localparam logic [CW-1:0] c_pre_load  = CW'(PRE_CYCLES - 1);
  localparam logic [CW-1:0] c_on_load   = CW'(MIN_ON - 1);
  localparam logic [CW-1:0] c_post_load = CW'(POST_CYCLES - 1);
  localparam logic [CW-1:0] c_off_load  = CW'(MIN_OFF);

  state_e        r_state, w_next_state;
  logic          r_mode, w_next_mode;
  logic          w_heat_valid, w_cool_valid, w_mode_req;
  logic          w_seq_load, w_lock_load;
  logic [CW-1:0] w_seq_load_val;
  logic          w_seq_zero, w_lock_zero;

  // Both requests high counts as no request at all.
  assign w_heat_valid = bus.heat_req & ~bus.cool_req;
  assign w_cool_valid = bus.cool_req & ~bus.heat_req;
  assign w_mode_req   = (r_mode == MODE_COOL) ? w_cool_valid : w_heat_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mode  <= MODE_HEAT;
    end else begin
      r_state <= w_next_state;
      r_mode  <= w_next_mode;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_next_mode    = r_mode;
    w_seq_load     = 1'b0;
    w_seq_load_val = '0;
    w_lock_load    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_heat_valid) begin
          w_next_state   = S_PRE;
          w_next_mode    = MODE_HEAT;
          w_seq_load     = 1'b1;
          w_seq_load_val = c_pre_load;
        end else if (w_cool_valid && w_lock_zero) begin
          w_next_state   = S_PRE;
          w_next_mode    = MODE_COOL;
          w_seq_load     = 1'b1;
          w_seq_load_val = c_pre_load;
        end
      end
      S_PRE: begin
        if (!w_mode_req) begin
          // Abort without post-purge; clear the counter so IDLE is clean.
          w_next_state = S_IDLE;
          w_seq_load   = 1'b1;
        end else if (w_seq_zero) begin
          w_next_state   = (r_mode == MODE_COOL) ? S_COOL : S_HEAT;
          w_seq_load     = 1'b1;
          w_seq_load_val = c_on_load;
        end
      end
      S_HEAT: begin
        if (w_seq_zero && !w_heat_valid) begin
          w_next_state   = S_POST;
          w_seq_load     = 1'b1;
          w_seq_load_val = c_post_load;
        end
      end
      S_COOL: begin
        if (w_seq_zero && !w_cool_valid) begin
          w_next_state   = S_POST;
          w_seq_load     = 1'b1;
          w_seq_load_val = c_post_load;
          w_lock_load    = 1'b1;
        end
      end
      S_POST: begin
        if (w_seq_zero) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_seq_load   = 1'b1;
      end
    endcase
  end

  hvac_downcounter #(.CW(CW)) u_seq_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_seq_load),
    .i_load_val (w_seq_load_val),
    .i_en       (1'b1),
    .o_zero     (w_seq_zero)
  );

  hvac_downcounter #(.CW(CW)) u_lock_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_lock_load),
    .i_load_val (c_off_load),
    .i_en       (1'b1),
    .o_zero     (w_lock_zero)
  );

  // Actuators decode from registered state only.
  assign bus.fan_on        = (r_state == S_PRE) || (r_state == S_HEAT) ||
                             (r_state == S_COOL) || (r_state == S_POST);
  assign bus.heater_on     = (r_state == S_HEAT);
  assign bus.compressor_on = (r_state == S_COOL);
  assign bus.lockout       = ~w_lock_zero;
  assign bus.conflict      = bus.heat_req & bus.cool_req;
  assign bus.state         = r_state;

endmodule
`default_nettype wire

// File: tb/tb_hvac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hvac_sequencer
// Brief    : Directed plus random stimulus against a phase/elapsed-time model
// Revision : 1.0
// ============================================================================
module tb_hvac_sequencer;

  localparam int PRE_CYCLES  = 4;
  localparam int MIN_ON      = 8;
  localparam int POST_CYCLES = 4;
  localparam int MIN_OFF     = 16;
  localparam int CW          = 8;

  localparam int P_IDLE = 0;
  localparam int P_PRE  = 1;
  localparam int P_HEAT = 2;
  localparam int P_COOL = 3;
  localparam int P_POST = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  hvac_sequencer_if bus();

  hvac_sequencer #(
    .PRE_CYCLES  (PRE_CYCLES),
    .MIN_ON      (MIN_ON),
    .POST_CYCLES (POST_CYCLES),
    .MIN_OFF     (MIN_OFF),
    .CW          (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: phase, cycles already spent in it, lockout cycles remaining.
  int m_phase   = P_IDLE;
  int m_elapsed = 0;
  int m_lock    = 0;
  bit m_cool    = 1'b0;
  bit cur_h     = 1'b0;
  bit cur_c     = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase   = P_IDLE;
    m_elapsed = 0;
    m_lock    = 0;
    m_cool    = 1'b0;
  endtask

  task automatic model_step(input bit h, input bit c);
    bit hv, cv, want;
    int nl;
    hv   = h && !c;
    cv   = c && !h;
    want = m_cool ? cv : hv;
    nl   = (m_lock > 0) ? m_lock - 1 : 0;
    case (m_phase)
      P_IDLE: begin
        if (hv) begin
          m_phase = P_PRE; m_cool = 1'b0; m_elapsed = 0;
        end else if (cv && m_lock == 0) begin
          m_phase = P_PRE; m_cool = 1'b1; m_elapsed = 0;
        end
      end
      P_PRE: begin
        if (!want) begin
          m_phase = P_IDLE; m_elapsed = 0;
        end else if (m_elapsed + 1 >= PRE_CYCLES) begin
          m_phase = m_cool ? P_COOL : P_HEAT; m_elapsed = 0;
        end else begin
          m_elapsed++;
        end
      end
      P_HEAT, P_COOL: begin
        if (m_elapsed + 1 >= MIN_ON && !want) begin
          if (m_phase == P_COOL) nl = MIN_OFF;
          m_phase = P_POST; m_elapsed = 0;
        end else if (m_elapsed < MIN_ON) begin
          m_elapsed++;
        end
      end
      default: begin
        if (m_elapsed + 1 >= POST_CYCLES) begin
          m_phase = P_IDLE; m_elapsed = 0;
        end else begin
          m_elapsed++;
        end
      end
    endcase
    m_lock = nl;
  endtask

  task automatic compare_outputs();
    check_eq("state",      bus.state,         m_phase);
    check_eq("fan_on",     bus.fan_on,        (m_phase != P_IDLE));
    check_eq("heater_on",  bus.heater_on,     (m_phase == P_HEAT));
    check_eq("compressor", bus.compressor_on, (m_phase == P_COOL));
    check_eq("lockout",    bus.lockout,       (m_lock != 0));
    check_eq("conflict",   bus.conflict,      (cur_h && cur_c));
    check_eq("no_heat_and_cool", bus.heater_on & bus.compressor_on, 0);
    check_eq("actuator_needs_fan", (bus.heater_on | bus.compressor_on) & ~bus.fan_on, 0);
  endtask

  // Apply inputs for one rising edge, advance the model, check on the falling edge.
  task automatic cycle(input bit h, input bit c);
    cur_h = h;
    cur_c = c;
    bus.heat_req = h;
    bus.cool_req = c;
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step(h, c);
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic run(input bit h, input bit c, input int n);
    for (int k = 0; k < n; k++) cycle(h, c);
  endtask

  // Called on a falling edge: reset lands between clock edges.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check_eq({tag, "_rst_fan"},        bus.fan_on,        0);
    check_eq({tag, "_rst_heater"},     bus.heater_on,     0);
    check_eq({tag, "_rst_compressor"}, bus.compressor_on, 0);
    check_eq({tag, "_rst_lockout"},    bus.lockout,       0);
    check_eq({tag, "_rst_state"},      bus.state,         P_IDLE);
    model_reset();
    cycle(cur_h, cur_c);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] pat;
    int         len;
    bus.heat_req = 1'b0;
    bus.cool_req = 1'b0;

    // Held in reset with heat requested, then released.
    run(1, 0, 3);
    rst_n = 1'b1;
    run(1, 0, 7);          // PRE x4, then two cycles of HEAT with request
    run(0, 0, 16);         // min-on completes, post-purge, idle

    // Full cool cycle, re-request immediately: lockout holds it in IDLE.
    run(0, 1, 14);
    run(0, 0, 4);
    run(0, 1, 30);
    async_reset("cool");   // mid-COOL
    run(0, 0, 20);

    // Conflicting requests from IDLE.
    run(1, 1, 10);

    // Heat to cool switch passes through POST, IDLE and PRE.
    run(1, 0, 7);
    run(0, 1, 30);
    run(0, 0, 30);

    // Reset while lockout counter is running.
    run(0, 1, 14);
    run(0, 0, 2);
    async_reset("lock");
    run(0, 0, 5);

    // Randomised request patterns with occasional asynchronous resets.
    for (int i = 0; i < 40; i++) begin
      pat = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 24);
      run(pat[0], pat[1], len);
      if ($urandom_range(0, 9) == 0) async_reset("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hvac_sequencer.md
Name: hvac_sequencer

Overview:
- Downstream stage of the air-conditioning controller `ac`.
- Consumes its heating/cooling requests and sequences the physical actuators: fan, heater and compressor.
- Enforces fan pre-purge, minimum run time, fan post-purge and a compressor anti-short-cycle lockout.
- Heater and compressor are never energised together.

Parameters:
PRE_CYCLES, 4, cycles fan runs alone before heater/compressor energise (>=1)
MIN_ON, 8, minimum cycles heater/compressor stays on once energised (>=1)
POST_CYCLES, 4, cycles fan runs alone after heater/compressor de-energise (>=1)
MIN_OFF, 16, compressor lockout cycles after compressor switches off (>=1)
CW, 8, width of internal down-counters; every cycle parameter must be < 2**CW

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
heat_req  input  1  heating request from ac
cool_req  input  1  cooling request from ac
fan_on  output  1  fan actuator enable
heater_on  output  1  heater actuator enable
compressor_on  output  1  compressor actuator enable
lockout  output  1  high while compressor lockout counter is non-zero
conflict  output  1  high in any cycle where heat_req and cool_req are both high
state  output  3  current FSM state encoding, for debug

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. clk and rst_n as named above.
- Reset: state=IDLE, all counters 0.
  - Outputs: fan_on=0, heater_on=0, compressor_on=0, lockout=0, conflict=0.
  - rst_n low mid-operation de-energises all actuators immediately (asynchronous); no post-purge.
- Requests are sampled on rising clk. Valid request = exactly one of heat_req/cool_req high.
  - Both high is treated as no request. conflict = heat_req & cool_req (combinational).
- Outputs are decoded from the registered state plus the lockout counter only; no input-to-actuator combinational path.
- States (encoding in package): IDLE=0, PRE=1, HEAT=2, COOL=3, POST=4.
- IDLE:
  - Actuator outputs all 0.
  - Valid heat_req -> PRE, mode=heat.
  - Valid cool_req with lockout=0 -> PRE, mode=cool.
  - cool_req while lockout=1 is held off and stays in IDLE.
  - On entry to PRE, cnt loads PRE_CYCLES-1.
- PRE:
  - fan_on=1.
  - If the latched-mode request is no longer validly asserted -> IDLE next edge (abort, no post-purge).
  - Else if cnt=0 -> HEAT or COOL per mode, cnt loads MIN_ON-1. Otherwise cnt decrements.
  - Net effect: fan runs exactly PRE_CYCLES cycles before the actuator energises.
- HEAT:
  - fan_on=1, heater_on=1.
  - cnt decrements to 0 and holds.
  - When cnt=0 and the valid heat request is absent -> POST, cnt loads POST_CYCLES-1.
  - Request loss before MIN_ON cycles is ignored until cnt=0.
- COOL: same as HEAT, with compressor_on=1. On exit to POST, lockout counter loads MIN_OFF.
- POST:
  - fan_on=1. cnt decrements; cnt=0 -> IDLE.
  - Requests during POST are ignored; re-entry always goes via IDLE then PRE.
- Lockout counter:
  - Independent; decrements every cycle while non-zero, in any state; saturates at 0.
  - lockout = (lockout_cnt != 0).
  - Does not block heat.
- Invariant: heater_on & compressor_on is never 1. heater_on|compressor_on implies fan_on.
- Mode change (heat -> cool) always passes through POST, IDLE and PRE.
- All counters are unsigned CW-bit; no wrap-around below 0.

Decomposition:
- Package hvac_pkg:
  - State encoding localparams.
  - MODE_HEAT/MODE_COOL constants.
  - Default cycle-count constants.
- One sub-module: hvac_downcounter (CW-bit, load/enable, saturating at 0, zero flag).
  - Instantiated twice: sequence counter and lockout counter.

Test Plan:
- Reset with heat_req=1, then release rst_n -> fan_on rises 1 cycle after release (IDLE->PRE); heater_on rises exactly 4 cycles later.
- heat_req pulsed for 2 cycles once in HEAT -> heater_on held 8 cycles total; then fan-only for 4 cycles; then all 0, state=IDLE.
- Full cool cycle, then cool_req reasserted in the first IDLE cycle -> lockout=1, no fan until 16 cycles after COOL exit. Then PRE, and compressor_on after 4 more cycles.
- heat_req=cool_req=1 from IDLE for 10 cycles -> conflict=1 all 10 cycles; all actuators 0, state stays 0.
- During HEAT, switch heat_req=0, cool_req=1 -> heater off after MIN_ON satisfied, POST 4 cycles, IDLE, PRE, then COOL.
  - Assert heater_on & compressor_on never 1 across the whole run.
- rst_n pulsed low mid-COOL (asynchronously, off clock edge) -> fan_on, compressor_on, lockout go 0 immediately; after release, state=IDLE.
